// File: rtl/input_debounce.sv
// Multi-channel pin conditioner: synchroniser, bounce-rejecting stability counter, clean level and edge strobes.
// Define DEBOUNCE_SYNC_EN for a two-flop synchroniser; otherwise a single capture register is used.
module input_debounce #(
  parameter int CHANNELS      = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_WIDTH     = $clog2(STABLE_CYCLES + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_en,
  input  logic [CHANNELS-1:0] raw,
  output logic [CHANNELS-1:0] clean,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                changed
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

  logic [CHANNELS-1:0]  r_s;
  logic [CHANNELS-1:0]  r_clean;
  logic [CHANNELS-1:0]  r_rise;
  logic [CHANNELS-1:0]  r_fall;
  logic                 r_changed;
  logic [CNT_WIDTH-1:0] r_cnt [CHANNELS];
  logic [CHANNELS-1:0]  w_diff;
  logic [CHANNELS-1:0]  w_done;

  // Stage 1: bring the pins into the clk domain
`ifdef DEBOUNCE_SYNC_EN
  logic [CHANNELS-1:0] r_s1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= '0;
      r_s  <= '0;
    end else begin
      r_s1 <= raw;
      r_s  <= r_s1;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) r_s <= '0;
    else       r_s <= raw;
  end
`endif

  // Stage 2: stability counting against the current clean level
  assign w_diff = r_s ^ r_clean;

  always_comb begin
    w_done = '0;
    for (int i = 0; i < CHANNELS; i++)
      w_done[i] = w_diff[i] & sample_en & (r_cnt[i] == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) r_cnt[i] <= '0;
      r_clean   <= '0;
      r_rise    <= '0;
      r_fall    <= '0;
      r_changed <= 1'b0;
    end else begin
      // A sample matching clean restarts the count from zero, rejecting glitches
      for (int i = 0; i < CHANNELS; i++) begin
        if (!w_diff[i] || w_done[i]) r_cnt[i] <= '0;
        else if (sample_en)          r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
      end
      r_clean   <= r_clean ^ w_done;
      r_rise    <= w_done & r_s;
      r_fall    <= w_done & ~r_s;
      r_changed <= |w_done;
    end
  end

  assign clean   = r_clean;
  assign rise    = r_rise;
  assign fall    = r_fall;
  assign changed = r_changed;

endmodule

// File: tb/tb_input_debounce.sv
// Scoreboard bench for input_debounce with STABLE_CYCLES=4: stimulus queues expected strobes, a monitor checks them.
module tb_input_debounce;

  localparam int STABLE = 4;
`ifdef DEBOUNCE_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 1;
`endif
  localparam int LAT = STABLE + SYNC;

  typedef struct {
    int         cyc;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] clean;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sample_en = 1'b1;
  logic [1:0] raw = 2'b00;
  logic [1:0] clean, rise, fall;
  logic       changed;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   done = 1'b0;
  exp_t q[$];

  input_debounce #(.CHANNELS(2), .STABLE_CYCLES(STABLE)) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .raw(raw),
    .clean(clean), .rise(rise), .fall(fall), .changed(changed)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic push(int lat, logic [1:0] r, logic [1:0] f, logic [1:0] c);
    exp_t e;
    e.cyc = cyc + lat; e.rise = r; e.fall = f; e.clean = c;
    q.push_back(e);
  endtask

  task automatic wait_cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_idle(string name, logic [1:0] exp_clean);
    check({name, "_clean"}, int'(clean), int'(exp_clean));
    check({name, "_rise"}, int'(rise), 0);
    check({name, "_fall"}, int'(fall), 0);
    check({name, "_changed"}, int'(changed), 0);
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!done) begin
      if ((rise | fall) != 2'b00 || changed) begin
        if (q.size() == 0) begin
          check("unexpected_strobe", int'({changed, rise, fall}), 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("strobe_cycle", cyc, e.cyc);
          check("strobe_rise", int'(rise), int'(e.rise));
          check("strobe_fall", int'(fall), int'(e.fall));
          check("strobe_clean", int'(clean), int'(e.clean));
          check("strobe_changed", int'(changed), 1);
        end
      end else if (q.size() > 0 && cyc > q[0].cyc) begin
        check("missed_strobe_at", cyc, q[0].cyc);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    // Reset state
    wait_cyc(3);
    check_idle("reset", 2'b00);
    reset = 1'b0;
    wait_cyc(2);

    // Clean step on channel 0
    raw = 2'b01; push(LAT, 2'b01, 2'b00, 2'b01);
    wait_cyc(LAT + 3);
    check_idle("step_hold", 2'b01);

    // Falling edge on channel 0
    raw = 2'b00; push(LAT, 2'b00, 2'b01, 2'b00);
    wait_cyc(LAT + 3);
    check_idle("fall_hold", 2'b00);

    // Bounce: short pulses are rejected, only the final hold is accepted
    raw = 2'b01; wait_cyc(2);
    raw = 2'b00; wait_cyc(2);
    raw = 2'b01; wait_cyc(2);
    raw = 2'b00; wait_cyc(2);
    check_idle("bounce_mid", 2'b00);
    raw = 2'b01; push(LAT, 2'b01, 2'b00, 2'b01);
    wait_cyc(LAT + 3);
    raw = 2'b00; push(LAT, 2'b00, 2'b01, 2'b00);
    wait_cyc(LAT + 3);

    // Slow strobe: sample_en one cycle in three; 4th qualified edge lands 13 edges after the change
    for (int k = 0; k < 20; k++) begin
      if (k == 0) begin
        raw = 2'b10; push(13, 2'b10, 2'b00, 2'b10);
      end
      sample_en = (k % 3 == 0);
      @(negedge clk);
    end
    sample_en = 1'b1;
    check_idle("slow_hold", 2'b10);
    raw = 2'b00; push(LAT, 2'b00, 2'b10, 2'b00);
    wait_cyc(LAT + 3);

    // Simultaneous transitions on both channels
    raw = 2'b11; push(LAT, 2'b11, 2'b00, 2'b11);
    wait_cyc(LAT + 3);
    raw = 2'b00; push(LAT, 2'b00, 2'b11, 2'b00);
    wait_cyc(LAT + 3);

    // Reset mid-count: channel 1 already high, channel 0 counting when reset lands on edge 4
    raw = 2'b10; push(LAT, 2'b10, 2'b00, 2'b10);
    wait_cyc(LAT + 3);
    raw = 2'b11;
    wait_cyc(3);
    reset = 1'b1;
    wait_cyc(1);
    check_idle("reset_mid", 2'b00);
    reset = 1'b0; push(LAT, 2'b11, 2'b00, 2'b11);
    wait_cyc(LAT + 4);
    check_idle("reset_after", 2'b11);

    wait_cyc(4);
    check("queue_empty", q.size(), 0);
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/input_debounce.md
# input_debounce

Multi-channel input conditioner between the raw quadrature pins and the `encoder` block. Per channel it synchronises the asynchronous pin into `clk`, then filters contact bounce with a stability counter. It emits a clean level plus single-cycle rise/fall strobes, so the encoder only ever sees one clean edge per detent transition. The optional `sample_en` strobe lets slow debounce timing share a common prescaler tick.

## Interface

- `CHANNELS`, default 2: number of independent inputs (e.g. encoder a, b).
- `STABLE_CYCLES`, default 16: consecutive qualified samples that must differ from `clean` before `clean` updates. Legal range is ≥1.
- `CNT_WIDTH`, default `$clog2(STABLE_CYCLES+1)`: per-channel counter width. Derived; do not override.

Ports:

- `clk` input 1: clock.
- `reset` input 1: synchronous, active-high reset.
- `sample_en` input 1: count-qualify strobe. Tie high to count every cycle.
- `raw` input CHANNELS: asynchronous pin inputs.
- `clean` output CHANNELS: debounced level, registered.
- `rise` output CHANNELS: one-cycle pulse when `clean[i]` goes 0→1.
- `fall` output CHANNELS: one-cycle pulse when `clean[i]` goes 1→0.
- `changed` output 1: registered OR of all `rise|fall`, aligned with them.

## Operation

- Channels are fully independent; all per-channel rules below apply to each bit `i`.
- **Sync stage:** a two-flop chain `raw[i]` → `s1` → `s`. `s` is the synchronised sample.
- **Counter `cnt[i]`:**
  - `s == clean[i]`: `cnt <= 0`, regardless of `sample_en`.
  - `s != clean[i]` and `sample_en == 0`: `cnt` holds.
  - `s != clean[i]`, `sample_en == 1`, and `cnt == STABLE_CYCLES-1`: `clean[i] <= s`, `cnt <= 0`. Pulse `rise[i]` if `s == 1`, else pulse `fall[i]`.
  - `s != clean[i]`, `sample_en == 1`, otherwise: `cnt <= cnt + 1`.
- **Glitch rejection:** if `s` returns to `clean[i]` before the count completes, `cnt` clears and no output changes. The count does not resume from its old value.
- `rise`/`fall` are high for exactly one clock, on the same edge that `clean` updates. They deassert on the next edge unconditionally.
- `rise[i]` and `fall[i]` are never high together. Different channels may pulse in the same cycle; `changed` is then high once.
- **Reset** (any cycle, including mid-count) clears:
  - `s1`, `s`, all `cnt`: 0.
  - `clean`: 0.
  - `rise`, `fall`, `changed`: 0.
- **After reset with `raw` high:** the debounce runs normally and produces one `rise` pulse. That pulse is intended; the encoder ignores it because it is idle in reset alignment.
- The counter never wraps: the maximum value held is `STABLE_CYCLES-1`.

## Timing

- With `sample_en` high, `raw[i]` changes before edge 1 and stays stable. `clean[i]` and the strobe update on edge `STABLE_CYCLES+2`, which is 18 with defaults.
- With `sample_en` pulsing every P cycles, `STABLE_CYCLES` qualified strobes are needed after `s` differs. Latency is about `2 + STABLE_CYCLES*P` cycles.
- `changed` has the same latency as `rise`/`fall`, not one cycle later.
- Throughput: one accepted transition per channel per `STABLE_CYCLES` qualified samples at most.

## Configuration

- `DEBOUNCE_SYNC_EN` defined: the two-flop synchroniser is used as described above.
- `DEBOUNCE_SYNC_EN` not defined: a single register stage replaces the chain, so `s` is `raw` registered once. This is for inputs already synchronous to `clk`.
  - All latencies are one cycle shorter: `clean` updates on edge `STABLE_CYCLES+1`.
  - All other behaviour is identical.

## Test plan

Test plan with `STABLE_CYCLES=4`, `DEBOUNCE_SYNC_EN` defined, `sample_en=1`, unless stated otherwise:

- **Clean step:** reset, then `raw=2'b01` held → `clean[0]` rises on edge 6 after the change. `rise[0]` and `changed` pulse for 1 cycle on edge 6; channel 1 stays 0.
- **Bounce:** toggle `raw[0]` 1,0,1,0 every 2 cycles, then hold 1 → exactly one `rise[0]`, 6 edges after the final toggle, with no `fall[0]` pulses.
- **Slow strobe:** `sample_en` high 1 cycle in 3, `raw[1]` 0→1 held → `clean[1]` updates after the 4th qualified strobe following sync. `cnt` holds between strobes.
- **Simultaneous:** both channels 0→1 on the same cycle → `rise=2'b11` for one cycle and `changed` high for one cycle.
- **Reset mid-count:** `raw[0]=1`, assert `reset` at edge 4 → `clean`, `rise`, `fall`, `changed` all 0. After release, the full 6-edge latency restarts.
- **Falling edge:** after `clean[0]=1`, drive `raw[0]=0` → `fall[0]` pulses once on edge 6 and `clean[0]` becomes 0.
